mc_datapath: RTL

MC_DATAPATH -- requirements
Module: mc_datapath

---
 rtl/mc_datapath.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_datapath.sv
// -----------------------------------------------------------------------------
// mc_datapath
//   Multi-cycle single-bus datapath. One operation at a time walks through a
//   small FSM; in each state exactly one source drives the shared bus, and
//   every architectural register except Z (fed by the ALU) and MDR (fed by
//   mdatain) loads from that bus.
//
// Ports
//   clk       rising-edge clock
//   clr       asynchronous active-low reset
//   op_valid  request strobe, accepted when op_ready is high
//   op_ready  high only in IDLE
//   op_code   0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR, 6 NOT, 7 MUL, 8 LDI
//   ra        destination register
//   rb, rc    source registers A and B
//   mdatain   memory data captured by LDI
//   done      one-cycle completion pulse
//   err       one-cycle illegal-opcode pulse (only together with done)
//   bus_out   current shared-bus value
//   hi_out    HI register
//   lo_out    LO register
//   rd_addr   debug read address
//   rd_data   R[rd_addr], combinational, no write bypass
// -----------------------------------------------------------------------------
module mc_datapath #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_AW-1:0] rb,
    input  logic [REG_AW-1:0] rc,
    input  logic [DATA_W-1:0] mdatain,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] bus_out,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    input  logic [REG_AW-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Shift amount uses only the low clog2(DATA_W) bits of the bus.
    localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SHL = 4'd4;
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_LDI = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        T_Y,
        T_Z,
        T_WLO,
        T_WHI,
        T_MDR,
        T_WMDR
    } state_t;

    state_t              state_q;
    logic [3:0]          op_q;
    logic [REG_AW-1:0]   ra_q;
    logic [REG_AW-1:0]   rb_q;
    logic [REG_AW-1:0]   rc_q;
    logic [DATA_W-1:0]   y_q;
    logic [2*DATA_W-1:0] z_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic [DATA_W-1:0]   mdr_q;
    logic                done_q;
    logic                err_q;

    logic [DATA_W-1:0]   regs [NREGS];
    logic [DATA_W-1:0]   bus;
    logic                reg_we;

    logic [DATA_W-1:0]   alu_lo;
    logic [2*DATA_W-1:0] alu_d;
    logic [2*DATA_W-1:0] mul_a;
    logic [2*DATA_W-1:0] mul_b;
    logic [SH_W-1:0]     sh_amt;

    // ------------------------------------------------------------------
    // Shared bus: one source per state, zero when nothing drives it.
    // ------------------------------------------------------------------
    always_comb begin
        bus = '0;
        case (state_q)
            T_Y:     bus = regs[rb_q];
            T_Z:     bus = regs[rc_q];
            T_WLO:   bus = z_q[DATA_W-1:0];
            T_WHI:   bus = z_q[2*DATA_W-1:DATA_W];
            T_WMDR:  bus = mdr_q;
            default: bus = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU: Y is operand A, the bus is operand B. Only MUL produces a
    // non-zero upper half of Z.
    // ------------------------------------------------------------------
    assign sh_amt = bus[SH_W-1:0];

    always_comb begin
        mul_a  = {{DATA_W{1'b0}}, y_q};
        mul_b  = {{DATA_W{1'b0}}, bus};
        alu_lo = '0;
        case (op_q)
            OP_ADD:  alu_lo = y_q + bus;
            OP_SUB:  alu_lo = y_q - bus;
            OP_AND:  alu_lo = y_q & bus;
            OP_OR:   alu_lo = y_q | bus;
            OP_SHL:  alu_lo = y_q << sh_amt;
            OP_SHR:  alu_lo = y_q >> sh_amt;
            OP_NOT:  alu_lo = ~bus;
            default: alu_lo = '0;
        endcase
        if (op_q == OP_MUL) begin
            alu_d = mul_a * mul_b;
        end else begin
            alu_d = {{DATA_W{1'b0}}, alu_lo};
        end
    end

    // ------------------------------------------------------------------
    // Register file. The single write port is the bus in T_WLO (non-MUL)
    // or T_WMDR; sources are always read in their own state, so aliasing
    // between ra/rb/rc needs no special handling.
    // ------------------------------------------------------------------
    assign reg_we = ((state_q == T_WLO) && (op_q != OP_MUL)) || (state_q == T_WMDR);

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [DATA_W-1:0] r_q;

            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    r_q <= '0;
                end else if (reg_we && (ra_q == REG_AW'(gi))) begin
                    r_q <= bus;
                end
            end

            assign regs[gi] = r_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM and datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            y_q     <= '0;
            z_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mdr_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (op_valid) begin
                        op_q <= op_code;
                        ra_q <= ra;
                        rb_q <= rb;
                        rc_q <= rc;
                        if (op_code <= OP_MUL) begin
                            state_q <= T_Y;
                        end else if (op_code == OP_LDI) begin
                            state_q <= T_MDR;
                        end else begin
                            // Illegal opcode: stay in IDLE, only flag it.
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end
                    end
                end
                T_Y: begin
                    y_q     <= bus;
                    state_q <= T_Z;
                end
                T_Z: begin
                    z_q     <= alu_d;
                    state_q <= T_WLO;
                end
                T_WLO: begin
                    if (op_q == OP_MUL) begin
                        lo_q    <= bus;
                        state_q <= T_WHI;
                    end else begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                T_WHI: begin
                    hi_q    <= bus;
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                T_MDR: begin
                    mdr_q   <= mdatain;
                    state_q <= T_WMDR;
                end
                T_WMDR: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign op_ready = (state_q == IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign bus_out  = bus;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign rd_data  = regs[rd_addr];

endmodule
